// File: rtl/entry_fd_pkg.sv
// Shared definitions for the MMCAM entry queue.
//   - default colour/generation/destination field widths
//   - packet struct {color, gen, dest, lr} at the default widths
//   - LR_L / LR_R encodings of the lr bit (bit 0 of a packet)
package entry_fd_pkg;

    localparam int COLOR_W_DEF = 4;
    localparam int GEN_W_DEF   = 4;
    localparam int DEST_W_DEF  = 10;

    localparam logic LR_L = 1'b0;
    localparam logic LR_R = 1'b1;

    typedef struct packed {
        logic [COLOR_W_DEF-1:0] color;
        logic [GEN_W_DEF-1:0]   gen;
        logic [DEST_W_DEF-1:0]  dest;
        logic                   lr;
    } pkt_t;

endpackage

// File: rtl/entry_fd_ram.sv
// DEPTH x W register array backing the entry queue.
// Ports:
//   clk      write clock, rising edge
//   we       write enable
//   wr_addr  write address
//   wr_data  write data
//   rd_addr  asynchronous read address
//   rd_data  contents at rd_addr (combinational)
// Storage is deliberately not reset: an entry is only ever read after it
// has been written, which the pointer/count logic in the parent guarantees.
module entry_fd_ram #(
    parameter int DEPTH = 4,
    parameter int W     = 19,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] wr_addr,
    input  logic [W-1:0]  wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [W-1:0]  rd_data
);

    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[wr_addr] <= wr_data;
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/entry_fd_queue.sv
// Entry queue in front of the MMCAM match logic. Buffers up to DEPTH
// {color, gen, dest, lr} packets in arrival order and presents the oldest
// one on a registered, first-word-fall-through output.
// Ports:
//   CP                 clock, rising edge
//   MR                 asynchronous active-low reset
//   EN                 stage enable; 0 freezes all state
//   IN_VALID/IN_READY  upstream handshake (IN_READY = EN & !FULL)
//   COLOR_GEN_DEST_LR  incoming packet, lr in bit 0
//   OUT_VALID/OUT_ACK  downstream handshake
//   OUT_PKT            oldest packet, registered
//   FIRE, FIRE_LR      one-cycle pulse (and lr bit) per downstream transfer
//   COUNT, FULL, EMPTY occupancy and its derived flags
module entry_fd_queue
    import entry_fd_pkg::*;
#(
    parameter  int COLOR_W = COLOR_W_DEF,
    parameter  int GEN_W   = GEN_W_DEF,
    parameter  int DEST_W  = DEST_W_DEF,
    parameter  int DEPTH   = 4,
    localparam int PKT_W   = COLOR_W + GEN_W + DEST_W + 1,
    localparam int CNT_W   = $clog2(DEPTH) + 1
) (
    input  logic             CP,
    input  logic             MR,
    input  logic             EN,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [PKT_W-1:0] COLOR_GEN_DEST_LR,
    output logic             OUT_VALID,
    input  logic             OUT_ACK,
    output logic [PKT_W-1:0] OUT_PKT,
    output logic             FIRE,
    output logic             FIRE_LR,
    output logic [CNT_W-1:0] COUNT,
    output logic             FULL,
    output logic             EMPTY
);

    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0]    wr_ptr, rd_ptr, rd_nxt;
    logic [CNT_W-1:0] count;
    logic [PKT_W-1:0] out_pkt, ram_rd;
    logic             fire, fire_lr;
    logic             push, pop;

    assign FULL      = (count == CNT_W'(DEPTH));
    assign EMPTY     = (count == '0);
    assign IN_READY  = EN & ~FULL;
    // The head entry lives in out_pkt whenever the queue is non-empty.
    assign OUT_VALID = ~EMPTY;
    assign push      = EN & IN_VALID & IN_READY;
    assign pop       = EN & OUT_VALID & OUT_ACK;
    assign rd_nxt    = rd_ptr + 1'b1;

    // ram[rd_ptr] always mirrors out_pkt; the read port looks one entry
    // ahead so the following packet is ready to load on a pop.
    entry_fd_ram #(
        .DEPTH (DEPTH),
        .W     (PKT_W),
        .AW    (AW)
    ) u_ram (
        .clk     (CP),
        .we      (push),
        .wr_addr (wr_ptr),
        .wr_data (COLOR_GEN_DEST_LR),
        .rd_addr (rd_nxt),
        .rd_data (ram_rd)
    );

    always_ff @(posedge CP or negedge MR) begin
        if (!MR) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            out_pkt <= '0;
            fire    <= 1'b0;
            fire_lr <= 1'b0;
        end else begin
            // pop already includes EN, so a frozen stage drops FIRE.
            fire    <= pop;
            fire_lr <= pop & (out_pkt[0] == LR_R);

            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_nxt;

            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase

            // Output register: load on push into an empty queue, advance on
            // pop. With one entry and a simultaneous push, the successor is
            // being written this very cycle, so take it from the input.
            // When the queue drains, out_pkt keeps its last value.
            if (push && EMPTY) begin
                out_pkt <= COLOR_GEN_DEST_LR;
            end else if (pop) begin
                if (count > CNT_W'(1))
                    out_pkt <= ram_rd;
                else if (push)
                    out_pkt <= COLOR_GEN_DEST_LR;
            end
        end
    end

    assign OUT_PKT = out_pkt;
    assign FIRE    = fire;
    assign FIRE_LR = fire_lr;
    assign COUNT   = count;

    a_no_overflow: assert property (@(posedge CP) disable iff (!MR)
        count <= CNT_W'(DEPTH));
    a_no_underflow: assert property (@(posedge CP) disable iff (!MR)
        !(pop && EMPTY && !push));

endmodule

// File: tb/tb_entry_fd_queue.sv
// Directed bench for entry_fd_queue at default parameters (DEPTH=4, 19-bit packets).
module tb_entry_fd_queue;
    import entry_fd_pkg::*;

    localparam int PKT_W = 19;
    localparam int CNT_W = 3;

    logic             CP = 1'b0;
    logic             MR, EN, IN_VALID, OUT_ACK;
    logic [PKT_W-1:0] COLOR_GEN_DEST_LR;
    logic             IN_READY, OUT_VALID, FIRE, FIRE_LR, FULL, EMPTY;
    logic [PKT_W-1:0] OUT_PKT;
    logic [CNT_W-1:0] COUNT;

    int n_cmp = 0;
    int n_bad = 0;

    entry_fd_queue dut (
        .CP                (CP),
        .MR                (MR),
        .EN                (EN),
        .IN_VALID          (IN_VALID),
        .IN_READY          (IN_READY),
        .COLOR_GEN_DEST_LR (COLOR_GEN_DEST_LR),
        .OUT_VALID         (OUT_VALID),
        .OUT_ACK           (OUT_ACK),
        .OUT_PKT           (OUT_PKT),
        .FIRE              (FIRE),
        .FIRE_LR           (FIRE_LR),
        .COUNT             (COUNT),
        .FULL              (FULL),
        .EMPTY             (EMPTY)
    );

    always #5 CP = ~CP;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle 1 time unit past it.
    task automatic tick();
        @(posedge CP);
        #1;
    endtask

    task automatic push1(input logic [PKT_W-1:0] p);
        IN_VALID = 1'b1;
        COLOR_GEN_DEST_LR = p;
        tick();
        IN_VALID = 1'b0;
    endtask

    logic [PKT_W-1:0] fill_v [4];

    initial begin
        fill_v[0] = 19'd120;
        fill_v[1] = 19'd110;
        fill_v[2] = 19'd121;
        fill_v[3] = 19'h79;

        MR = 1'b0; EN = 1'b1; IN_VALID = 1'b0; OUT_ACK = 1'b0;
        COLOR_GEN_DEST_LR = '0;
        #3;
        chk("rst_out_valid", 32'(OUT_VALID), 32'd0);
        chk("rst_out_pkt",   32'(OUT_PKT),   32'd0);
        chk("rst_count",     32'(COUNT),     32'd0);
        chk("rst_empty",     32'(EMPTY),     32'd1);
        chk("rst_full",      32'(FULL),      32'd0);
        chk("rst_fire",      32'(FIRE),      32'd0);
        chk("rst_in_ready",  32'(IN_READY),  32'd1);
        tick();
        MR = 1'b1;
        tick();

        // Single pass
        push1(19'd120);
        chk("sp_valid", 32'(OUT_VALID), 32'd1);
        chk("sp_pkt",   32'(OUT_PKT),   32'd120);
        chk("sp_count", 32'(COUNT),     32'd1);
        chk("sp_nofire", 32'(FIRE),     32'd0);
        OUT_ACK = 1'b1;
        tick();
        OUT_ACK = 1'b0;
        chk("sp_fire",    32'(FIRE),      32'd1);
        chk("sp_fire_lr", 32'(FIRE_LR),   32'(LR_L));
        chk("sp_empty",   32'(EMPTY),     32'd1);
        chk("sp_novalid", 32'(OUT_VALID), 32'd0);
        chk("sp_pkt_hold", 32'(OUT_PKT),  32'd120);
        tick();
        chk("sp_fire_end", 32'(FIRE), 32'd0);

        // Fill / back-pressure
        for (int i = 0; i < 4; i++) push1(fill_v[i]);
        chk("fill_full",     32'(FULL),     32'd1);
        chk("fill_in_ready", 32'(IN_READY), 32'd0);
        chk("fill_count",    32'(COUNT),    32'd4);
        chk("fill_head",     32'(OUT_PKT),  32'd120);
        push1(19'd7);
        chk("fill_reject_count", 32'(COUNT), 32'd4);
        OUT_ACK = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("drain_pkt%0d", i), 32'(OUT_PKT), 32'(fill_v[i]));
            tick();
            chk($sformatf("drain_fire%0d", i), 32'(FIRE),    32'd1);
            chk($sformatf("drain_lr%0d", i),   32'(FIRE_LR), (i < 2) ? 32'(LR_L) : 32'(LR_R));
        end
        OUT_ACK = 1'b0;
        chk("drain_empty", 32'(EMPTY), 32'd1);
        tick();
        chk("drain_fire_end", 32'(FIRE), 32'd0);

        // Wrap-around with COUNT held at 2
        push1(19'd200);
        push1(19'd201);
        for (int i = 0; i < 10; i++) begin
            IN_VALID = 1'b1;
            COLOR_GEN_DEST_LR = 19'(202 + i);
            OUT_ACK = 1'b1;
            chk($sformatf("wrap_pkt%0d", i), 32'(OUT_PKT), 32'(200 + i));
            tick();
            chk($sformatf("wrap_cnt%0d", i), 32'(COUNT), 32'd2);
            chk($sformatf("wrap_fire%0d", i), 32'(FIRE), 32'd1);
        end
        IN_VALID = 1'b0;
        chk("wrap_tail0", 32'(OUT_PKT), 32'd210);
        tick();
        chk("wrap_tail1", 32'(OUT_PKT), 32'd211);
        tick();
        OUT_ACK = 1'b0;
        chk("wrap_empty", 32'(EMPTY), 32'd1);

        // Simultaneous push & pop at COUNT==1
        push1(19'd110);
        chk("sim_head", 32'(OUT_PKT), 32'd110);
        IN_VALID = 1'b1;
        COLOR_GEN_DEST_LR = 19'h79;
        OUT_ACK = 1'b1;
        tick();
        IN_VALID = 1'b0;
        OUT_ACK = 1'b0;
        chk("sim_fire",    32'(FIRE),      32'd1);
        chk("sim_fire_lr", 32'(FIRE_LR),   32'(LR_L));
        chk("sim_pkt",     32'(OUT_PKT),   32'h79);
        chk("sim_valid",   32'(OUT_VALID), 32'd1);
        chk("sim_count",   32'(COUNT),     32'd1);

        // Freeze with EN=0
        push1(19'h155);
        chk("frz_count0", 32'(COUNT), 32'd2);
        EN = 1'b0;
        IN_VALID = 1'b1;
        COLOR_GEN_DEST_LR = 19'h3FF;
        OUT_ACK = 1'b1;
        #1;
        chk("frz_in_ready", 32'(IN_READY), 32'd0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("frz_fire%0d", i),  32'(FIRE),    32'd0);
            chk($sformatf("frz_count%0d", i), 32'(COUNT),   32'd2);
            chk($sformatf("frz_pkt%0d", i),   32'(OUT_PKT), 32'h79);
        end
        EN = 1'b1;
        IN_VALID = 1'b0;
        tick();
        chk("frz_res_fire0", 32'(FIRE),    32'd1);
        chk("frz_res_lr0",   32'(FIRE_LR), 32'(LR_R));
        chk("frz_res_pkt",   32'(OUT_PKT), 32'h155);
        tick();
        OUT_ACK = 1'b0;
        chk("frz_res_lr1",   32'(FIRE_LR), 32'(LR_R));
        chk("frz_res_empty", 32'(EMPTY),   32'd1);

        // Reset mid-stream with COUNT=3 and FIRE high
        push1(19'd1);
        push1(19'd2);
        push1(19'd3);
        push1(19'd4);
        OUT_ACK = 1'b1;
        tick();
        OUT_ACK = 1'b0;
        chk("mr_pre_count", 32'(COUNT), 32'd3);
        chk("mr_pre_fire",  32'(FIRE),  32'd1);
        MR = 1'b0;
        #1;
        chk("mr_count", 32'(COUNT),     32'd0);
        chk("mr_valid", 32'(OUT_VALID), 32'd0);
        chk("mr_pkt",   32'(OUT_PKT),   32'd0);
        chk("mr_fire",  32'(FIRE),      32'd0);
        chk("mr_fire_lr", 32'(FIRE_LR), 32'd0);
        chk("mr_empty", 32'(EMPTY),     32'd1);
        tick();
        MR = 1'b1;
        OUT_ACK = 1'b1;
        tick();
        OUT_ACK = 1'b0;
        chk("mr_rel_empty", 32'(EMPTY), 32'd1);
        chk("mr_rel_fire",  32'(FIRE),  32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
